down_counter_timer: RTL and testbench

//   Synchronous loadable down counter with start/busy/done handshake.
//   It counts a loaded value down to zero on qualified ticks, then flags completion.
//   It is the counting-down complement of ripple_carry_counter.

---
 rtl/down_counter_timer.sv | 113 +++++++++++
 tb/tb_down_counter_timer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/down_counter_timer.sv
// rtl/down_counter_timer.sv - loadable down counter timer with start/busy/done handshake
//
// Purpose: loads load_val on an accepted start, then counts it down to zero
// on enabled cycles and pulses done for one cycle. It is used as a delay or
// timeout timer. abort leaves RUN at once, keeps q, and gives no done pulse.
//
// Optional feature: macro DOWN_COUNTER_TIMER_AUTO_RELOAD_EN. When it is
// defined, RUN reloads from the captured start value instead of reaching 0.
// done pulses on every wrap, and only abort leaves RUN.
//
// Ports:
//   clk       in   1      clock, all state updates on posedge
//   reset_n   in   1      asynchronous active-low reset
//   start     in   1      load load_val and begin counting (accepted in IDLE/DONE)
//   load_val  in   WIDTH  initial count, captured on accepted start
//   enable    in   1      count tick qualifier
//   abort     in   1      stop counting immediately, no done
//   q         out  WIDTH  current count (registered)
//   busy      out  1      high while in RUN (registered)
//   done      out  1      one-cycle completion pulse (registered)

module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t state;

`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
  // Only the periodic mode ever reads the captured start value back.
  logic [WIDTH-1:0] reload_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      q     <= ZERO;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
      reload_q <= ZERO;
`endif
    end else begin
      // done is a pulse. It is raised only on the cycle that produces it.
      done <= 1'b0;
      case (state)
        RUN: begin
          if (abort) begin
            // abort has priority over enable, and q freezes where it is.
            state <= IDLE;
            busy  <= 1'b0;
          end else if (enable) begin
            // Use <= ONE rather than == ONE, so q can never wrap below zero.
            if (q <= ONE) begin
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
              q    <= reload_q;
              done <= 1'b1;
`else
              q     <= ZERO;
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
`endif
            end else begin
              q <= q - ONE;
            end
          end
        end
        default: begin
          // IDLE and DONE share start acceptance. An accepted start in DONE
          // restarts back to back with no idle gap.
          if (abort) begin
            state <= IDLE;
          end else if (start) begin
            q <= load_val;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
            reload_q <= load_val;
`endif
            if (load_val != ZERO) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else if (state == DONE) begin
            state <= IDLE;
            q     <= ZERO;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_down_counter_timer.sv
// tb/tb_down_counter_timer.sv - self-checking bench for down_counter_timer

module tb_down_counter_timer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         enable = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] q;
  logic         busy;
  logic         done;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Behavioural view: the timer is running while a count is outstanding.
  // m_done marks a completion cycle.
  int m_q = 0;
  int m_rel = 0;
  bit m_busy = 1'b0;
  bit m_done = 1'b0;

  down_counter_timer #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .load_val(load_val),
    .enable(enable), .abort(abort), .q(q), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model. Sampling happens on the negedge.
  always @(negedge clk) begin
    if (chk_en && reset_n) begin
      chk("cyc_q", int'(q), m_q);
      chk("cyc_busy", int'(busy), int'(m_busy));
      chk("cyc_done", int'(done), int'(m_done));
    end
  end

  task automatic model_reset();
    m_q = 0; m_rel = 0; m_busy = 1'b0; m_done = 1'b0;
  endtask

  // Drive one cycle of inputs and work out what the timer must show afterwards.
  task automatic step(input bit s, input int lv, input bit en, input bit ab);
    int nq;
    bit nb;
    bit nd;
    start = s; load_val = W'(lv); enable = en; abort = ab;
    nq = m_q; nb = m_busy; nd = 1'b0;
    if (m_busy) begin
      if (ab) begin
        nb = 1'b0;
      end else if (en) begin
        if (m_q == 1) begin
          nd = 1'b1;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
          nq = m_rel;
`else
          nq = 0; nb = 1'b0;
`endif
        end else begin
          nq = m_q - 1;
        end
      end
    end else if (!ab) begin
      if (s) begin
        nq = lv; m_rel = lv;
        nb = (lv != 0);
        nd = (lv == 0);
      end else if (m_done) begin
        nq = 0;
      end
    end
    @(posedge clk);
    #1;
    m_q = nq; m_busy = nb; m_done = nd;
  endtask

  initial begin
    // 1. Reset state, then an asynchronous reset in the middle of a count.
    #12;
    chk("rst_q", int'(q), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    step(1, 7, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("pre_rst_q5", int'(q), 5);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_q", int'(q), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_done", int'(done), 0);
    model_reset();
    #3 reset_n = 1'b1;
    step(0, 0, 0, 0);

    // 2. One-shot count of 3 with enable held high.
    step(1, 3, 1, 0);
    chk("os_q3", int'(q), 3);
    chk("os_busy3", int'(busy), 1);
    step(0, 0, 1, 0);
    chk("os_q2", int'(q), 2);
    step(0, 0, 1, 0);
    chk("os_q1", int'(q), 1);
    step(0, 0, 1, 0);
    chk("os_q0", int'(q), 0);
    chk("os_done", int'(done), 1);
    chk("os_busy0", int'(busy), 0);
    step(0, 0, 1, 0);
    chk("os_done_clr", int'(done), 0);

    // 3. Gated count: load 2, then the enable pattern 1,0,0,1.
    step(1, 2, 0, 0);
    chk("gate_q2", int'(q), 2);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("gate_hold", int'(q), 1);
    chk("gate_nodone", int'(done), 0);
    step(0, 0, 1, 0);
    chk("gate_q0", int'(q), 0);
    chk("gate_done", int'(done), 1);
    step(0, 0, 0, 0);

    // 4. Abort at q=4 of a count of 9, then a start with zero load.
    step(1, 9, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
    chk("ab_pre_q4", int'(q), 4);
    step(0, 0, 1, 1);
    chk("ab_q4", int'(q), 4);
    chk("ab_busy", int'(busy), 0);
    chk("ab_done", int'(done), 0);
    step(1, 6, 1, 1);
    chk("ab_start_drop_q", int'(q), 4);
    chk("ab_start_drop_busy", int'(busy), 0);
    step(1, 0, 0, 0);
    chk("zero_q", int'(q), 0);
    chk("zero_done", int'(done), 1);
    chk("zero_busy", int'(busy), 0);
    step(0, 0, 0, 0);
    chk("zero_done_clr", int'(done), 0);

    // 5. A start held high through DONE restarts back to back.
    //    A start pulsed during RUN is ignored.
    step(1, 2, 1, 0);
    step(1, 2, 1, 0);
    step(1, 2, 1, 0);
    chk("b2b_done", int'(done), 1);
    step(1, 2, 1, 0);
    chk("b2b_q2", int'(q), 2);
    chk("b2b_busy", int'(busy), 1);
    step(1, 7, 0, 0);
    chk("ign_start_q", int'(q), 2);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Full-width load counts down without wrapping.
    step(1, 15, 1, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0);
    chk("full_end_q", int'(q), 0);

`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
    // 6. Periodic mode: 3,2,1,3,2,1 with done on each wrap.
    step(1, 3, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("ar_q3", int'(q), 3);
    chk("ar_done", int'(done), 1);
    chk("ar_busy", int'(busy), 1);
    step(1, 9, 1, 0);
    chk("ar_ign_start", int'(q), 2);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    chk("ar_abort_busy", int'(busy), 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("ar_abort_nodone", int'(done), 0);
`endif

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
